// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter for an async FIFO with registered read data.
// It turns the FIFO port into a valid/ready stream behind a 2-entry skid buffer.
module fifo_rd_stream_adapter #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  fifo_rrdy_i,
   output logic                  fifo_re_o,
   input  logic [DATA_WIDTH-1:0] fifo_dout_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic [1:0]            level_o
);

   logic [DATA_WIDTH-1:0] bufMem [2];
   logic                  headIdx;
   logic                  tailIdx;
   logic [1:0]            wordCount;
   logic                  inflight;
   logic                  popBeat;
   logic                  pushBeat;
   logic                  readAccept;
   logic [2:0]            occupancy;

   assign popBeat  = m_valid_o & m_ready_i;
   assign pushBeat = inflight;

   // Projected occupancy once this cycle's pop and arriving word settle;
   // a new read is only issued when that leaves room for its data.
   assign occupancy  = {1'b0, wordCount} + {2'b00, inflight} - {2'b00, popBeat};
   assign fifo_re_o  = fifo_rrdy_i & ~rst_i & ~flush_i & (occupancy <= 3'd1);
   assign readAccept = fifo_re_o & fifo_rrdy_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wordCount <= 2'd0;
         inflight  <= 1'b0;
         headIdx   <= 1'b0;
         tailIdx   <= 1'b0;
         bufMem[0] <= '0;
         bufMem[1] <= '0;
      end else if (flush_i) begin
         wordCount <= 2'd0;
         inflight  <= 1'b0;
         headIdx   <= 1'b0;
         tailIdx   <= 1'b0;
      end else begin
         inflight  <= readAccept;
         wordCount <= wordCount + 2'(pushBeat) - 2'(popBeat);
         if (pushBeat) begin
            bufMem[tailIdx] <= fifo_dout_i;
            tailIdx         <= ~tailIdx;
         end
         if (popBeat) begin
            headIdx <= ~headIdx;
         end
      end
   end

   assign m_valid_o = (wordCount != 2'd0);
   assign m_data_o  = bufMem[headIdx];
   assign level_o   = wordCount;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: a queue-based FIFO model feeds the DUT,
// a monitor scores every stream pop against the expected word queue.
module tb_fifo_rd_stream_adapter;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       flush_i;
   logic       fifo_rrdy_i;
   logic       fifo_re_o;
   logic [7:0] fifo_dout_i;
   logic       m_valid_o;
   logic       m_ready_i;
   logic [7:0] m_data_o;
   logic [1:0] level_o;

   fifo_rd_stream_adapter #(.DATA_WIDTH(8)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .fifo_rrdy_i (fifo_rrdy_i),
      .fifo_re_o   (fifo_re_o),
      .fifo_dout_i (fifo_dout_i),
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .m_data_o    (m_data_o),
      .level_o     (level_o)
   );

   always #5 clk_i = ~clk_i;

   logic [7:0] fifoQ[$];
   logic [7:0] expQ[$];
   bit         rrdyEn      = 1'b1;
   bit         accPending  = 1'b0;
   int         rdCount     = 0;
   int         nChecks     = 0;
   int         nPass       = 0;

   bit         reS  [7] = '{1, 1, 1, 1, 0, 0, 0};
   bit         vldS [7] = '{0, 0, 1, 1, 1, 1, 0};
   logic [7:0] datS [7] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
   bit         reB  [6] = '{1, 1, 0, 0, 0, 0};
   logic [1:0] lvB  [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else nPass++;
   endtask

   function automatic void updRrdy();
      fifo_rrdy_i = rrdyEn && (fifoQ.size() != 0);
   endfunction

   task automatic load(input logic [7:0] w);
      fifoQ.push_back(w);
      expQ.push_back(w);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   // FIFO model: registered read data appears after the accepting edge
   always @(posedge clk_i) begin
      #1;
      if (accPending && fifoQ.size() != 0) fifo_dout_i = fifoQ.pop_front();
      updRrdy();
   end

   always @(negedge clk_i) begin
      accPending = fifo_re_o & fifo_rrdy_i;
      if (accPending) rdCount++;
   end

   // Monitor: invariants every cycle, scoreboard compare on every pop
   always @(negedge clk_i) begin
      chk("re_without_rrdy", 32'(fifo_re_o & ~fifo_rrdy_i), 32'd0);
      chk("level_max", 32'(level_o <= 2'd2), 32'd1);
      if (!rst_i && !flush_i && m_valid_o && m_ready_i) begin
         if (expQ.size() == 0) begin
            chk("unexpected_pop", 32'(m_data_o), 32'hFFFF_FFFF);
         end else begin
            chk("sb_data", 32'(m_data_o), 32'(expQ.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] w;
      int         r0;
      int         guard;
      rst_i       = 1'b1;
      flush_i     = 1'b0;
      m_ready_i   = 1'b1;
      fifo_dout_i = 8'h00;
      load(8'h11); load(8'h22); load(8'h33); load(8'h44);
      updRrdy();

      for (int c = 0; c < 3; c++) begin
         tick();
         @(negedge clk_i);
         chk("rst_re",    32'(fifo_re_o), 32'd0);
         chk("rst_valid", 32'(m_valid_o), 32'd0);
         chk("rst_data",  32'(m_data_o),  32'd0);
         chk("rst_level", 32'(level_o),   32'd0);
      end

      tick();
      rst_i = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk_i);
         chk("strm_re",    32'(fifo_re_o), 32'(reS[c]));
         chk("strm_valid", 32'(m_valid_o), 32'(vldS[c]));
         if (vldS[c]) chk("strm_data", 32'(m_data_o), 32'(datS[c]));
         tick();
      end

      m_ready_i = 1'b0;
      r0 = rdCount;
      for (int i = 0; i < 6; i++) load(8'hB0 + 8'(i));
      updRrdy();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_i);
         chk("bp_re",    32'(fifo_re_o), 32'(reB[c]));
         chk("bp_level", 32'(level_o),   32'(lvB[c]));
         if (c >= 2) chk("bp_hold_data", 32'(m_data_o), 32'hB0);
         tick();
      end
      chk("bp_reads", 32'(rdCount - r0), 32'd2);

      m_ready_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_i);
         chk("drain_valid", 32'(m_valid_o), 32'd1);
         chk("drain_data",  32'(m_data_o),  32'hB0 + 32'(c));
         tick();
      end
      @(negedge clk_i);
      chk("drain_empty", 32'(m_valid_o), 32'd0);
      tick();

      for (int i = 0; i < 200; i++) begin
         w = 8'($urandom);
         load(w);
      end
      updRrdy();
      guard = 0;
      while (expQ.size() != 0 && guard < 5000) begin
         m_ready_i = 1'($urandom_range(0, 1));
         rrdyEn    = ($urandom_range(0, 3) != 0);
         updRrdy();
         tick();
         guard++;
      end
      chk("rand_drained", 32'(expQ.size()), 32'd0);
      m_ready_i = 1'b1;
      rrdyEn    = 1'b1;
      updRrdy();
      repeat (3) tick();
      @(negedge clk_i);
      chk("rand_level_end", 32'(level_o), 32'd0);
      tick();

      m_ready_i = 1'b0;
      load(8'hA0); load(8'hA1); load(8'hA2); load(8'hA3);
      updRrdy();
      @(negedge clk_i);
      chk("fl_re0", 32'(fifo_re_o), 32'd1);
      tick();
      @(negedge clk_i);
      chk("fl_re1", 32'(fifo_re_o), 32'd1);
      tick();
      m_ready_i = 1'b1;
      @(negedge clk_i);
      chk("fl_head", 32'(m_data_o), 32'hA0);
      chk("fl_re2",  32'(fifo_re_o), 32'd1);
      tick();
      m_ready_i = 1'b0;
      flush_i   = 1'b1;
      @(negedge clk_i);
      chk("fl_re_blocked", 32'(fifo_re_o), 32'd0);
      chk("fl_level_pre",  32'(level_o),   32'd1);
      tick();
      flush_i = 1'b0;
      void'(expQ.pop_front());
      void'(expQ.pop_front());
      @(negedge clk_i);
      chk("fl_level_post", 32'(level_o),   32'd0);
      chk("fl_valid_post", 32'(m_valid_o), 32'd0);
      chk("fl_re_resume",  32'(fifo_re_o), 32'd1);
      tick();
      @(negedge clk_i);
      chk("fl_valid_wait", 32'(m_valid_o), 32'd0);
      tick();
      @(negedge clk_i);
      chk("fl_next_valid", 32'(m_valid_o), 32'd1);
      chk("fl_next_data",  32'(m_data_o),  32'hA3);
      chk("fl_next_level", 32'(level_o),   32'd1);
      tick();

      m_ready_i = 1'b1;
      @(negedge clk_i);
      chk("empty_rrdy",  32'(fifo_rrdy_i), 32'd0);
      chk("empty_re",    32'(fifo_re_o),   32'd0);
      chk("empty_valid", 32'(m_valid_o),   32'd1);
      tick();
      @(negedge clk_i);
      chk("empty_fall",  32'(m_valid_o), 32'd0);
      chk("empty_level", 32'(level_o),   32'd0);
      chk("empty_re2",   32'(fifo_re_o), 32'd0);
      tick();

      chk("sb_leftover", 32'(expQ.size()), 32'd0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
